// File: rtl/tablero_pkg.sv
// Shared board definitions: cell indexing, cursor FSM states and grid geometry
// common to the cursor controller and the selection-rectangle generator.
package tablero_pkg;

  localparam int unsigned CELL_W    = 4;
  localparam int unsigned NUM_CELLS = 9;

  // Grid line positions in pixels, shared with the rectangle generator
  localparam int unsigned GRID_DX0 = 233;
  localparam int unsigned GRID_DX1 = 456;
  localparam int unsigned GRID_DY0 = 175;
  localparam int unsigned GRID_DY1 = 340;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT, FULL} sel_state_t;

  function automatic cell_t next_cell(input cell_t c);
    return (c == cell_t'(NUM_CELLS - 1)) ? '0 : c + cell_t'(1);
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Raw push-button conditioner: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on each accepted rising edge.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            r_level;
  logic            r_pulse;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        // Level held for DEBOUNCE_CYCLES consecutive samples: accept it
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_pulse <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/cell_select_ctrl.sv
// 3x3 selection cursor controller: moves skip occupied cells, commits report
// the cell and player, with per-turn timeout and full-board detection.
module cell_select_ctrl
  import tablero_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TURN_CYCLES     = 500_000_000,
  parameter int unsigned NUM_CELLS       = 9
) (
  input  logic                 clk,
  input  logic                 boton_rst,
  input  logic                 btn_next,
  input  logic                 btn_conf,
  input  logic                 clear_board,
  output cell_t                contador,
  output logic                 sel_valid,
  output cell_t                sel_cell,
  output logic                 sel_player,
  output logic                 turno,
  output logic [NUM_CELLS-1:0] occupied,
  output logic                 board_full,
  output logic                 timeout_pulse
);

  localparam int unsigned TimerW = $clog2(TURN_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TURN_CYCLES - 1);

  logic w_next_p, w_conf_p;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk    (clk),
    .rst    (boton_rst),
    .i_btn  (btn_next),
    .o_pulse(w_next_p)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_conf (
    .clk    (clk),
    .rst    (boton_rst),
    .i_btn  (btn_conf),
    .o_pulse(w_conf_p)
  );

  sel_state_t           r_state, w_state;
  cell_t                r_contador, w_contador;
  cell_t                r_cand, w_cand;
  logic [3:0]           r_tries, w_tries;
  logic [NUM_CELLS-1:0] r_occ, w_occ;
  logic [TimerW-1:0]    r_timer, w_timer;
  logic                 r_full, w_full;
  logic                 r_turno, w_turno;
  logic                 r_sel_valid, w_sel_valid;
  cell_t                r_sel_cell, w_sel_cell;
  logic                 r_sel_player, w_sel_player;
  logic                 r_timeout, w_timeout;

  always_ff @(posedge clk or posedge boton_rst) begin
    if (boton_rst) begin
      r_state      <= IDLE;
      r_contador   <= '0;
      r_cand       <= '0;
      r_tries      <= '0;
      r_occ        <= '0;
      r_timer      <= '0;
      r_full       <= 1'b0;
      r_turno      <= 1'b0;
      r_sel_valid  <= 1'b0;
      r_sel_cell   <= '0;
      r_sel_player <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_contador   <= w_contador;
      r_cand       <= w_cand;
      r_tries      <= w_tries;
      r_occ        <= w_occ;
      r_timer      <= w_timer;
      r_full       <= w_full;
      r_turno      <= w_turno;
      r_sel_valid  <= w_sel_valid;
      r_sel_cell   <= w_sel_cell;
      r_sel_player <= w_sel_player;
      r_timeout    <= w_timeout;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_contador   = r_contador;
    w_cand       = r_cand;
    w_tries      = r_tries;
    w_occ        = r_occ;
    w_timer      = r_timer;
    w_full       = r_full;
    w_turno      = r_turno;
    w_sel_valid  = 1'b0;
    w_sel_cell   = r_sel_cell;
    w_sel_player = r_sel_player;
    w_timeout    = 1'b0;

    if (clear_board) begin
      w_state    = IDLE;
      w_contador = '0;
      w_occ      = '0;
      w_full     = 1'b0;
      w_turno    = 1'b0;
      w_timer    = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_conf_p && !r_occ[r_contador]) begin
            // Commit beats a coincident timeout; COMMIT clears the timer
            w_state = COMMIT;
          end else begin
            if (r_timer == TimerMax) begin
              w_timeout = 1'b1;
              w_turno   = ~r_turno;
              w_timer   = '0;
            end else begin
              w_timer = r_timer + TimerW'(1);
            end
            if (w_next_p && !w_conf_p) begin
              w_state = SEARCH;
              w_cand  = next_cell(r_contador);
              w_tries = '0;
            end
          end
        end
        SEARCH: begin
          if (!r_occ[r_cand]) begin
            w_contador = r_cand;
            w_state    = IDLE;
          end else if (r_tries == 4'd8) begin
            w_full  = 1'b1;
            w_state = FULL;
          end else begin
            w_cand  = next_cell(r_cand);
            w_tries = r_tries + 4'd1;
          end
        end
        COMMIT: begin
          w_occ[r_contador] = 1'b1;
          w_sel_valid       = 1'b1;
          w_sel_cell        = r_contador;
          w_sel_player      = r_turno;
          w_turno           = ~r_turno;
          w_timer           = '0;
          w_state           = SEARCH;
          w_cand            = next_cell(r_contador);
          w_tries           = '0;
        end
        FULL: ;
        default: w_state = IDLE;
      endcase
    end
  end

  assign contador      = r_contador;
  assign sel_valid     = r_sel_valid;
  assign sel_cell      = r_sel_cell;
  assign sel_player    = r_sel_player;
  assign turno         = r_turno;
  assign occupied      = r_occ;
  assign board_full    = r_full;
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_cell_select_ctrl.sv
// Directed bench for cell_select_ctrl with short debounce and turn periods.
module tb_cell_select_ctrl;

  logic       clk = 1'b0;
  logic       boton_rst, btn_next, btn_conf, clear_board;
  logic [3:0] contador, sel_cell;
  logic       sel_valid, sel_player, turno, board_full, timeout_pulse;
  logic [8:0] occupied;

  int checks   = 0;
  int failures = 0;
  int n;

  cell_select_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TURN_CYCLES    (100),
    .NUM_CELLS      (9)
  ) dut (
    .clk          (clk),
    .boton_rst    (boton_rst),
    .btn_next     (btn_next),
    .btn_conf     (btn_conf),
    .clear_board  (clear_board),
    .contador     (contador),
    .sel_valid    (sel_valid),
    .sel_cell     (sel_cell),
    .sel_player   (sel_player),
    .turno        (turno),
    .occupied     (occupied),
    .board_full   (board_full),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic nxt, input logic cnf);
    btn_next = nxt;
    btn_conf = cnf;
    tick(8);
    btn_next = 1'b0;
    btn_conf = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    boton_rst = 1'b1;
    tick(2);
    boton_rst = 1'b0;
  endtask

  initial begin
    boton_rst   = 1'b1;
    btn_next    = 1'b0;
    btn_conf    = 1'b0;
    clear_board = 1'b0;
    tick(2);
    check("rst_contador", contador, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_sel_cell", sel_cell, 0);
    check("rst_sel_player", sel_player, 0);
    check("rst_turno", turno, 0);
    check("rst_occupied", occupied, 0);
    check("rst_board_full", board_full, 0);
    check("rst_timeout", timeout_pulse, 0);
    boton_rst = 1'b0;

    // Single next press: move lands on the 8th edge, holding gives no repeat
    btn_next = 1'b1;
    tick(7);
    check("next_not_early", contador, 0);
    tick(1);
    check("next_move", contador, 1);
    tick(50);
    check("next_hold_once", contador, 1);
    btn_next = 1'b0;
    tick(8);

    // Commit at cell 0
    do_reset();
    btn_conf = 1'b1;
    tick(7);
    check("conf_not_early", sel_valid, 0);
    tick(1);
    check("conf_valid", sel_valid, 1);
    check("conf_cell", sel_cell, 0);
    check("conf_player", sel_player, 0);
    check("conf_occ", occupied, 9'h001);
    check("conf_turno", turno, 1);
    tick(1);
    check("conf_advance", contador, 1);
    check("conf_valid_1cyc", sel_valid, 0);
    btn_conf = 1'b0;
    tick(8);

    // Fill cells 1..7, then search skips them
    do_reset();
    press(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1);
    check("fill_occ", occupied, 9'h0FE);
    check("fill_cursor", contador, 8);
    check("fill_turno", turno, 1);
    press(1'b1, 1'b0);
    check("wrap_to_0", contador, 0);
    press(1'b1, 1'b0);
    check("skip_to_8", contador, 8);
    press(1'b0, 1'b1);
    check("commit8_cell", sel_cell, 8);
    check("commit8_player", sel_player, 1);
    check("commit8_cursor", contador, 0);
    press(1'b0, 1'b1);
    tick(4);
    check("full_flag", board_full, 1);
    check("full_occ", occupied, 9'h1FF);
    check("full_cursor", contador, 0);
    check("full_player", sel_player, 0);
    check("full_turno", turno, 1);
    btn_next = 1'b1;
    btn_conf = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (sel_valid) n++;
    end
    btn_next = 1'b0;
    btn_conf = 1'b0;
    check("full_no_commit", n, 0);
    check("full_cursor_hold", contador, 0);
    n = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (timeout_pulse) n++;
    end
    check("full_no_timeout", n, 0);
    check("full_turno_hold", turno, 1);

    // clear_board from FULL
    clear_board = 1'b1;
    tick(1);
    clear_board = 1'b0;
    check("clr_occ", occupied, 0);
    check("clr_full", board_full, 0);
    check("clr_cursor", contador, 0);
    check("clr_turno", turno, 0);
    check("clr_sel_cell_hold", sel_cell, 0);

    // Turn timeout: first pulse 100 cycles after the clear edge, then every 100
    n = 0;
    while (n < 200) begin
      tick(1);
      n++;
      if (timeout_pulse) break;
    end
    check("timeout1_cycles", n, 100);
    check("timeout1_turno", turno, 1);
    check("timeout1_cursor", contador, 0);
    n = 0;
    while (n < 200) begin
      tick(1);
      n++;
      if (timeout_pulse) break;
    end
    check("timeout2_cycles", n, 100);
    check("timeout2_turno", turno, 0);

    // Coincident next and conf at free cell 4: conf wins
    do_reset();
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    check("to_cell4", contador, 4);
    press(1'b1, 1'b1);
    check("both_cell", sel_cell, 4);
    check("both_occ", occupied, 9'h010);
    check("both_advance", contador, 5);
    check("both_turno", turno, 1);

    // Async reset in the middle of a search
    btn_next = 1'b1;
    tick(7);
    check("search_hold", contador, 5);
    boton_rst = 1'b1;
    btn_next  = 1'b0;
    #1;
    check("arst_cursor", contador, 0);
    check("arst_occ", occupied, 0);
    check("arst_turno", turno, 0);
    check("arst_sel_cell", sel_cell, 0);
    tick(1);
    boton_rst = 1'b0;
    tick(2);
    check("arst_idle_cursor", contador, 0);
    press(1'b1, 1'b0);
    check("arst_then_move", contador, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
